// File: rtl/derive_real_size_pkg.sv
// Shared definitions for the derive_real_size actor family.
package derive_real_size_pkg;

  // Filter extension of the 8-tap HEVC interpolation path.
  localparam int DIFF_8TAP = 7;

  // Underflow handling mode for the size subtraction.
  typedef enum logic [0:0] {
    SZ_WRAP = 1'b0,
    SZ_SAT  = 1'b1
  } sz_mode_e;

  // Tag width needed to name one of 'flux' fluxes.
  function automatic int tag_w(input int flux);
    return $clog2(flux);
  endfunction

endpackage

// File: rtl/derive_real_size_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Search ptr, ptr+1, ... modulo N and grant the first requester.
  always_comb begin
    logic          found_s;
    logic [IW-1:0] cand_s;
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = IW'((int'(ptr) + i) % N);
      if (en && !found_s && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        gnt_idx     = cand_s;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/derive_real_size_rr.sv
// Round-robin real-size recovery: pops tagged extended sizes from FLUX input
// FIFOs, removes the filter extension and pushes {tag, size} through one
// registered output stage.
module derive_real_size_rr
  import derive_real_size_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 7,
  parameter int DIFF       = DIFF_8TAP,
  parameter int SAT        = 0,
  parameter int TAG_W      = tag_w(FLUX)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLUX-1:0]            rd_empty,
  input  logic [FLUX*DATA_WIDTH-1:0] rd_dout,
  output logic [FLUX-1:0]            rd_read,
  input  logic [FLUX-1:0]            wr_full,
  output logic                       wr_write,
  output logic [TAG_W+DATA_WIDTH-1:0] wr_din,
  input  logic                       ufl_clr,
  output logic [FLUX-1:0]            underflow
);

  localparam sz_mode_e                MODE   = (SAT != 0) ? SZ_SAT : SZ_WRAP;
  localparam logic [DATA_WIDTH-1:0]   DIFF_V = DATA_WIDTH'(DIFF);

  logic                  out_valid_r;
  logic [TAG_W-1:0]      out_tag_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [TAG_W-1:0]      ptr_r;
  logic [FLUX-1:0]       underflow_r;

  logic [FLUX-1:0]       elig_s;
  logic                  fire_s;
  logic                  load_ok_s;
  logic [FLUX-1:0]       gnt_s;
  logic [TAG_W-1:0]      gnt_idx_s;
  logic                  grant_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic                  under_s;
  logic [DATA_WIDTH-1:0] real_s;

  rr_arbiter #(.N(FLUX), .IW(TAG_W)) u_arb (
    .req     (elig_s),
    .en      (load_ok_s & ~rst),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Handshake decode: eligibility, output fire and stage-free condition.
  always_comb begin
    elig_s    = ~rd_empty & ~wr_full;
    fire_s    = out_valid_r & ~wr_full[out_tag_r] & ~rst;
    load_ok_s = ~out_valid_r | fire_s;
    grant_s   = |gnt_s;
  end

  // Size recovery on the granted head: subtract, then wrap or clamp.
  always_comb begin
    head_s  = rd_dout[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    under_s = (head_s < DIFF_V);
    if (under_s && (MODE == SZ_SAT)) begin
      real_s = '0;
    end else begin
      real_s = head_s - DIFF_V;
    end
  end

  // Output stage, round-robin pointer and sticky underflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_tag_r   <= '0;
      out_data_r  <= '0;
      ptr_r       <= '0;
      underflow_r <= '0;
    end else begin
      if (grant_s) begin
        out_valid_r <= 1'b1;
        out_tag_r   <= gnt_idx_s;
        out_data_r  <= real_s;
        if (gnt_idx_s == TAG_W'(FLUX - 1)) begin
          ptr_r <= '0;
        end else begin
          ptr_r <= gnt_idx_s + TAG_W'(1);
        end
      end else if (fire_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      // A new underflow on a flux beats a simultaneous clear.
      underflow_r <= (ufl_clr ? {FLUX{1'b0}} : underflow_r) | (gnt_s & {FLUX{under_s}});
    end
  end

  assign rd_read   = gnt_s;
  assign wr_write  = fire_s;
  assign wr_din    = {out_tag_r, out_data_r};
  assign underflow = underflow_r;

endmodule

// File: tb/tb_derive_real_size_rr.sv
// Directed scoreboard bench for derive_real_size_rr (FLUX=2, DATA_WIDTH=7,
// DIFF=7), wrap and saturate instances driven by the same stimulus.
module tb_derive_real_size_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_empty;
  logic [13:0] rd_dout;
  logic [1:0]  wr_full;
  logic        ufl_clr;

  logic [1:0]  rd_read_w, rd_read_s;
  logic        wr_write_w, wr_write_s;
  logic [7:0]  din_w, din_s;
  logic [1:0]  uf_w, uf_s;

  int checks = 0;
  int errors = 0;
  // Each entry: {expected din saturate, expected din wrap}.
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  derive_real_size_rr #(.FLUX(2), .DATA_WIDTH(7), .DIFF(7), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .rd_empty(rd_empty), .rd_dout(rd_dout), .rd_read(rd_read_w),
    .wr_full(wr_full), .wr_write(wr_write_w), .wr_din(din_w), .ufl_clr(ufl_clr),
    .underflow(uf_w)
  );

  derive_real_size_rr #(.FLUX(2), .DATA_WIDTH(7), .DIFF(7), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .rd_empty(rd_empty), .rd_dout(rd_dout), .rd_read(rd_read_s),
    .wr_full(wr_full), .wr_write(wr_write_s), .wr_din(din_s), .ufl_clr(ufl_clr),
    .underflow(uf_s)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_heads(input int h0, input int h1);
    rd_dout = {7'(h1), 7'(h0)};
  endtask

  task automatic push_exp(input int tag, input int wrap_v, input int sat_v);
    sb_q.push_back({1'(tag), 7'(sat_v), 1'(tag), 7'(wrap_v)});
  endtask

  // A write is expected this cycle: pop the scoreboard and compare both instances.
  task automatic expect_write(input string tag);
    logic [15:0] e;
    chk({tag, "_wr"}, {14'd0, wr_write_s, wr_write_w}, 16'h0003);
    chk({tag, "_sbq"}, 16'(sb_q.size() != 0), 16'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_din_w"}, {8'd0, din_w}, {8'd0, e[7:0]});
      chk({tag, "_din_s"}, {8'd0, din_s}, {8'd0, e[15:8]});
    end else begin
      chk({tag, "_din_w"}, {8'd0, din_w}, 16'hffff);
    end
  endtask

  task automatic expect_read(input string tag, input logic [1:0] exp);
    chk({tag, "_rd_w"}, {14'd0, rd_read_w}, {14'd0, exp});
    chk({tag, "_rd_s"}, {14'd0, rd_read_s}, {14'd0, exp});
  endtask

  initial begin
    // Reset with active inputs for two edges.
    rst = 1'b1; rd_empty = 2'b00; wr_full = 2'b00; ufl_clr = 1'b0;
    set_heads(15, 20);
    @(posedge clk);
    step();
    samp();
    expect_read("rst", 2'b00);
    chk("rst_wr", {15'd0, wr_write_w}, 16'd0);
    chk("rst_din", {8'd0, din_w}, 16'd0);
    chk("rst_uf", {14'd0, uf_w}, 16'd0);

    // Single flux: flux 0 head 15 -> {0,8}.
    step();
    rst = 1'b0; rd_empty = 2'b10;
    samp();
    expect_read("single", 2'b01);
    chk("single_nowr", {15'd0, wr_write_w}, 16'd0);
    push_exp(0, 8, 8);
    step();
    rd_empty = 2'b11;
    samp();
    expect_write("single");
    expect_read("single_idle", 2'b00);
    step();
    samp();
    chk("drain_nowr", {15'd0, wr_write_w}, 16'd0);

    // Fairness: both fluxes ready, pointer now at 1.
    step();
    rd_empty = 2'b00; set_heads(20, 30);
    samp();
    expect_read("fair0", 2'b10);
    push_exp(1, 23, 23);
    for (int i = 0; i < 4; i++) begin
      step();
      samp();
      expect_write("fair_w");
      if ((i % 2) == 0) begin
        expect_read("fair_r0", 2'b01);
        push_exp(0, 13, 13);
      end else begin
        expect_read("fair_r1", 2'b10);
        push_exp(1, 23, 23);
      end
    end

    // Back-pressure on tag 1 blocks flux 0 too.
    step();
    wr_full = 2'b10;
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("bp_nowr", {15'd0, wr_write_w}, 16'd0);
      chk("bp_din", {8'd0, din_w}, {8'd0, sb_q[0][7:0]});
      expect_read("bp", 2'b00);
      step();
    end
    wr_full = 2'b00;
    samp();
    expect_write("bp_rel");
    expect_read("bp_rel", 2'b01);
    push_exp(0, 13, 13);
    step();
    rd_empty = 2'b11;
    samp();
    expect_write("bp_drain");

    // Underflow on flux 1: head 3 -> wrap 124, saturate 0.
    step();
    rd_empty = 2'b01; set_heads(20, 3);
    samp();
    expect_read("uf", 2'b10);
    push_exp(1, 124, 0);
    step();
    rd_empty = 2'b11;
    samp();
    expect_write("uf");
    chk("uf_flag_w", {14'd0, uf_w}, 16'h0002);
    chk("uf_flag_s", {14'd0, uf_s}, 16'h0002);

    // Clear together with a new flux-1 underflow: set wins.
    step();
    rd_empty = 2'b01; ufl_clr = 1'b1;
    samp();
    expect_read("uf_clrset", 2'b10);
    push_exp(1, 124, 0);
    step();
    rd_empty = 2'b11; ufl_clr = 1'b0;
    samp();
    expect_write("uf_clrset");
    chk("uf_setwins", {14'd0, uf_w}, 16'h0002);

    // Clear alone.
    step();
    ufl_clr = 1'b1;
    step();
    ufl_clr = 1'b0;
    samp();
    chk("uf_clr_w", {14'd0, uf_w}, 16'd0);
    chk("uf_clr_s", {14'd0, uf_s}, 16'd0);

    // Boundary: head equal to DIFF gives 0 and no underflow.
    step();
    rd_empty = 2'b10; set_heads(7, 3);
    samp();
    expect_read("eq", 2'b01);
    push_exp(0, 0, 0);
    step();
    rd_empty = 2'b11;
    samp();
    expect_write("eq");
    chk("eq_uf", {14'd0, uf_w}, 16'd0);

    // Reset while an item is pending behind full outputs.
    step();
    rd_empty = 2'b00; set_heads(20, 30);
    samp();
    expect_read("mid", 2'b10);
    step();
    rd_empty = 2'b11; wr_full = 2'b11; rst = 1'b1;
    samp();
    chk("mid_nowr", {15'd0, wr_write_w}, 16'd0);
    step();
    rst = 1'b0; wr_full = 2'b00; rd_empty = 2'b00;
    samp();
    chk("mid_rst_wr", {15'd0, wr_write_w}, 16'd0);
    chk("mid_rst_din", {8'd0, din_w}, 16'd0);
    expect_read("mid_ptr0", 2'b01);
    push_exp(0, 13, 13);
    step();
    rd_empty = 2'b11;
    samp();
    expect_write("mid_after");
    chk("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
